// File: rtl/key_scan.sv
// key_scan: 4x4 matrix keypad scanner with row synchroniser and debouncer.
//
// Drives one keypad column low at a time, samples the synchronised rows at
// the end of each column dwell, and debounces both the press and the release
// of a single key. Each accepted press or release raises key_flag for one
// cycle. key_out and key_state are valid in that same cycle.
//
// Ports:
//   Clk       - system clock
//   Rst       - asynchronous active-high reset
//   key_r     - keypad rows, active-low (key_r[0] is row 0)
//   key_c     - keypad column drive, active-low, one-hot-zero
//   key_out   - code of last accepted key, {row[1:0], col[1:0]}
//   key_flag  - one-cycle pulse on each accepted press and release
//   key_state - debounced state: 0 = key held, 1 = released
module key_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 1000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] key_r,
    output logic [3:0] key_c,
    output logic [3:0] key_out,
    output logic       key_flag,
    output logic       key_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEB_CNT);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      r1_q, rs_q;
    logic [3:0]      rpat_q, rpat_d;
    logic [1:0]      col_q, col_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [3:0]      key_c_q;
    logic [3:0]      key_out_q, key_out_d;
    logic            key_flag_q, key_flag_d;
    logic            key_state_q, key_state_d;

    // Exactly one low row is a valid single-key pattern.
    logic            rs_valid;
    logic [1:0]      rs_row;

    always_comb begin
        rs_valid = 1'b1;
        rs_row   = 2'd0;
        case (rs_q)
            4'b1110: rs_row = 2'd0;
            4'b1101: rs_row = 2'd1;
            4'b1011: rs_row = 2'd2;
            4'b0111: rs_row = 2'd3;
            default: rs_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rpat_d      = rpat_q;
        col_d       = col_q;
        div_cnt_d   = div_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        key_out_d   = key_out_q;
        key_flag_d  = 1'b0;
        key_state_d = key_state_q;

        case (state_q)
            SCAN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (rs_valid) begin
                        rpat_d    = rs_q;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (rs_q != rpat_q) begin
                    div_cnt_d = '0;
                    state_d   = SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    // rs equals rpat here, so the live decode gives the row.
                    deb_cnt_d   = '0;
                    key_out_d   = {rs_row, col_q};
                    key_flag_d  = 1'b1;
                    key_state_d = 1'b0;
                    state_d     = PRESSED;
                end else begin
                    deb_cnt_d = deb_cnt_q + BW'(1);
                end
            end
            PRESSED: begin
                deb_cnt_d = '0;
                if (rs_q == 4'hF) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rs_q != 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d   = '0;
                    div_cnt_d   = '0;
                    col_d       = col_q + 2'd1;
                    key_flag_d  = 1'b1;
                    key_state_d = 1'b1;
                    state_d     = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + BW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= SCAN;
            r1_q        <= 4'hF;
            rs_q        <= 4'hF;
            rpat_q      <= 4'hF;
            col_q       <= 2'd0;
            div_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            key_c_q     <= 4'b1110;
            key_out_q   <= 4'h0;
            key_flag_q  <= 1'b0;
            key_state_q <= 1'b1;
        end else begin
            r1_q        <= key_r;
            rs_q        <= r1_q;
            state_q     <= state_d;
            rpat_q      <= rpat_d;
            col_q       <= col_d;
            div_cnt_q   <= div_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            // Column drive registered from the next column so it tracks col_q.
            key_c_q     <= ~(4'b0001 << col_d);
            key_out_q   <= key_out_d;
            key_flag_q  <= key_flag_d;
            key_state_q <= key_state_d;
        end
    end

    assign key_c     = key_c_q;
    assign key_out   = key_out_q;
    assign key_flag  = key_flag_q;
    assign key_state = key_state_q;

endmodule
